// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one 32-bit ALU between two requesters.
//   Each grant runs through IDLE -> EXEC -> RESP. Grants are round-robin, and the
//   response is tagged with the requester id.
// Ports:
//   clk, reset              - rising-edge clock, synchronous active-high reset
//   req{0,1}_valid/_ready   - request handshake (ready is combinational, IDLE only)
//   req{0,1}_op/_a/_b       - opcode and operands, sampled only at acceptance
//   resp_valid/_ready       - response handshake; resp_* are held until accepted
//   resp_id/_s/_zero/_err   - requester id, result, result==0, unsupported opcode
//   grant_cnt0/1            - saturating per-port acceptance counters
//
// ALU: combinational 32-bit ALU. Unsupported opcodes give s_o=0 and err_o=1.
//   op_i, num1_i, num2_i -> s_o, err_o

module ALU (
    input  logic [3:0]  op_i,
    input  logic [31:0] num1_i,
    input  logic [31:0] num2_i,
    output logic [31:0] s_o,
    output logic        err_o
);
    always_comb begin
        s_o   = '0;
        err_o = 1'b0;
        case (op_i)
            4'b0000: s_o = num1_i - num2_i;
            4'b0001: s_o = num1_i + num2_i;
            4'b0010: s_o = num1_i & num2_i;
            4'b0011: s_o = num1_i | num2_i;
            4'b1100: s_o = num1_i >> num2_i[4:0];
            default: err_o = 1'b1;
        endcase
    end
endmodule

module alu_rr_arbiter #(
    parameter int unsigned PRIO_INIT = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [31:0]      resp_s,
    output logic             resp_zero,
    output logic             resp_err,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StExec = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    localparam logic             PtrInit = (PRIO_INIT != 0);
    localparam logic [CNT_W-1:0] CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic             ptr_q, ptr_d;         // 1: port 1 wins a tie
    logic [3:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic             id_q, id_d;
    logic             resp_id_q, resp_id_d;
    logic [31:0]      resp_s_q, resp_s_d;
    logic             resp_zero_q, resp_zero_d;
    logic             resp_err_q, resp_err_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic             in_idle;
    logic             sel1;
    logic [31:0]      alu_s;
    logic             alu_err;

    ALU u_alu (
        .op_i   (op_q),
        .num1_i (a_q),
        .num2_i (b_q),
        .s_o    (alu_s),
        .err_o  (alu_err)
    );

    // Readies are gated by reset so nothing is accepted while reset is high.
    always_comb begin
        in_idle    = (state_q == StIdle) && !reset;
        sel1       = req1_valid && (!req0_valid || ptr_q);
        req0_ready = in_idle && req0_valid && !sel1;
        req1_ready = in_idle && req1_valid && sel1;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        resp_id_d   = resp_id_q;
        resp_s_d    = resp_s_q;
        resp_zero_d = resp_zero_q;
        resp_err_d  = resp_err_q;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;

        case (state_q)
            StIdle: begin
                if (req0_ready) begin
                    op_d    = req0_op;
                    a_d     = req0_a;
                    b_d     = req0_b;
                    id_d    = 1'b0;
                    state_d = StExec;
                    if (cnt0_q != '1) cnt0_d = cnt0_q + CntOne;
                end else if (req1_ready) begin
                    op_d    = req1_op;
                    a_d     = req1_a;
                    b_d     = req1_b;
                    id_d    = 1'b1;
                    state_d = StExec;
                    if (cnt1_q != '1) cnt1_d = cnt1_q + CntOne;
                end
            end
            StExec: begin
                resp_id_d = id_q;
                if (alu_err) begin
                    resp_s_d    = '0;
                    resp_zero_d = 1'b0;
                    resp_err_d  = 1'b1;
                end else begin
                    resp_s_d    = alu_s;
                    resp_zero_d = (alu_s == 32'd0);
                    resp_err_d  = 1'b0;
                end
                state_d = StResp;
            end
            StResp: begin
                if (resp_ready) begin
                    ptr_d   = ~resp_id_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            ptr_q       <= PtrInit;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            resp_id_q   <= 1'b0;
            resp_s_q    <= '0;
            resp_zero_q <= 1'b0;
            resp_err_q  <= 1'b0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            resp_id_q   <= resp_id_d;
            resp_s_q    <= resp_s_d;
            resp_zero_q <= resp_zero_d;
            resp_err_q  <= resp_err_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
        end
    end

    assign resp_valid = (state_q == StResp);
    assign resp_id    = resp_id_q;
    assign resp_s     = resp_s_q;
    assign resp_zero  = resp_zero_q;
    assign resp_err   = resp_err_q;
    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
endmodule
